// File: rtl/fast_square_bb_deframer.sv
// ---------------------------------------------------------------------------
// fast_square_bb_deframer
//
// Receiver for the framed baseband stream of the comb/decimate chain.
// A frame is one header word (32-bit reset count as {q,i}) followed by
// exactly MARKER_COUNT marker words. Once a frame is acquired, every
// non-marker word is forwarded as a sample until a marker word shows up,
// which starts re-acquisition.
//
// Ports:
//   clock            sole clock
//   reset            asynchronous active-low reset, clears all state
//   strobe_in        input word valid this cycle
//   i_in, q_in       I/Q word (header: reset count [15:0] / [31:16])
//   sample_strobe    1-cycle pulse, i_out/q_out carry a forwarded sample
//   i_out, q_out     last forwarded sample (held between pulses)
//   locked           frame acquired, samples being forwarded
//   header_strobe    1-cycle pulse, reset_count just updated
//   reset_count      last accepted header value
//   reset_gap        1-cycle pulse, accepted header is not previous + 1
//   sync_error       1-cycle pulse, marker run had the wrong length
//   sync_error_count saturating count of sync_error pulses
// ---------------------------------------------------------------------------
module fast_square_bb_deframer #(
    parameter logic [15:0] MARKER_WORD  = 16'h8000,
    parameter int          MARKER_COUNT = 201
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        strobe_in,
    input  logic [15:0] i_in,
    input  logic [15:0] q_in,
    output logic        sample_strobe,
    output logic [15:0] i_out,
    output logic [15:0] q_out,
    output logic        locked,
    output logic        header_strobe,
    output logic [31:0] reset_count,
    output logic        reset_gap,
    output logic        sync_error,
    output logic [15:0] sync_error_count
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CAND    = 2'd1,
        MARKERS = 2'd2,
        DATA    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mcount_q, mcount_d;
    logic [31:0] cand_q, cand_d;
    logic        have_hdr_q, have_hdr_d;
    logic        locked_q, locked_d;
    logic        smp_q, smp_d;
    logic        hdr_q, hdr_d;
    logic        gap_q, gap_d;
    logic        serr_q, serr_d;
    logic [15:0] i_out_q, i_out_d;
    logic [15:0] q_out_q, q_out_d;
    logic [31:0] rc_q, rc_d;
    logic [15:0] errcnt_q, errcnt_d;

    logic        is_marker;
    logic [31:0] word;
    logic        run_ok;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign is_marker = (i_in == MARKER_WORD) && (q_in == MARKER_WORD);
    assign word      = {q_in, i_in};
    // Widen the run length so a MARKER_COUNT above 255 simply never matches.
    assign run_ok    = (32'(mcount_q) == 32'(MARKER_COUNT));

    always_comb begin
        state_d    = state_q;
        mcount_d   = mcount_q;
        cand_d     = cand_q;
        have_hdr_d = have_hdr_q;
        locked_d   = locked_q;
        smp_d      = 1'b0;
        hdr_d      = 1'b0;
        gap_d      = 1'b0;
        serr_d     = 1'b0;
        i_out_d    = i_out_q;
        q_out_d    = q_out_q;
        rc_d       = rc_q;
        errcnt_d   = errcnt_q;

        if (strobe_in) begin
            case (state_q)
                HUNT: begin
                    if (!is_marker) begin
                        cand_d  = word;
                        state_d = CAND;
                    end
                end
                CAND: begin
                    if (is_marker) begin
                        mcount_d = 8'd1;
                        state_d  = MARKERS;
                    end else begin
                        cand_d = word;
                    end
                end
                MARKERS: begin
                    if (is_marker) begin
                        mcount_d = sat_inc8(mcount_q);
                    end else if (run_ok) begin
                        // Accept: publish header and forward this word as
                        // the first sample of the new frame.
                        rc_d       = cand_q;
                        hdr_d      = 1'b1;
                        gap_d      = have_hdr_q && (cand_q != 32'd0) &&
                                     (cand_q != rc_q + 32'd1);
                        have_hdr_d = 1'b1;
                        locked_d   = 1'b1;
                        smp_d      = 1'b1;
                        i_out_d    = i_in;
                        q_out_d    = q_in;
                        cand_d     = word;
                        mcount_d   = 8'd0;
                        state_d    = DATA;
                    end else begin
                        serr_d   = 1'b1;
                        errcnt_d = sat_inc16(errcnt_q);
                        cand_d   = word;
                        mcount_d = 8'd0;
                        state_d  = CAND;
                    end
                end
                DATA: begin
                    if (is_marker) begin
                        // The previous sample becomes the candidate header;
                        // it was already emitted and stays emitted.
                        locked_d = 1'b0;
                        mcount_d = 8'd1;
                        state_d  = MARKERS;
                    end else begin
                        smp_d   = 1'b1;
                        i_out_d = i_in;
                        q_out_d = q_in;
                        cand_d  = word;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            mcount_q   <= 8'd0;
            cand_q     <= 32'd0;
            have_hdr_q <= 1'b0;
            locked_q   <= 1'b0;
            smp_q      <= 1'b0;
            hdr_q      <= 1'b0;
            gap_q      <= 1'b0;
            serr_q     <= 1'b0;
            i_out_q    <= 16'd0;
            q_out_q    <= 16'd0;
            rc_q       <= 32'd0;
            errcnt_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            mcount_q   <= mcount_d;
            cand_q     <= cand_d;
            have_hdr_q <= have_hdr_d;
            locked_q   <= locked_d;
            smp_q      <= smp_d;
            hdr_q      <= hdr_d;
            gap_q      <= gap_d;
            serr_q     <= serr_d;
            i_out_q    <= i_out_d;
            q_out_q    <= q_out_d;
            rc_q       <= rc_d;
            errcnt_q   <= errcnt_d;
        end
    end

    assign sample_strobe    = smp_q;
    assign i_out            = i_out_q;
    assign q_out            = q_out_q;
    assign locked           = locked_q;
    assign header_strobe    = hdr_q;
    assign reset_count      = rc_q;
    assign reset_gap        = gap_q;
    assign sync_error       = serr_q;
    assign sync_error_count = errcnt_q;

endmodule

// File: tb/tb_fast_square_bb_deframer.sv
// ---------------------------------------------------------------------------
// Testbench for fast_square_bb_deframer: randomized I/Q frames driven into
// the DUT, expected pulse events queued by a word-level reference model and
// compared by an independent monitor whenever the DUT emits a pulse.
// ---------------------------------------------------------------------------
module tb_fast_square_bb_deframer;

    localparam logic [15:0] MW = 16'h8000;
    localparam int          MC = 201;

    logic        clock = 1'b0;
    logic        reset;
    logic        strobe_in;
    logic [15:0] i_in, q_in;
    logic        sample_strobe, locked, header_strobe, reset_gap, sync_error;
    logic [15:0] i_out, q_out, sync_error_count;
    logic [31:0] reset_count;

    fast_square_bb_deframer #(.MARKER_WORD(MW), .MARKER_COUNT(MC)) dut (
        .clock(clock), .reset(reset), .strobe_in(strobe_in),
        .i_in(i_in), .q_in(q_in),
        .sample_strobe(sample_strobe), .i_out(i_out), .q_out(q_out),
        .locked(locked), .header_strobe(header_strobe),
        .reset_count(reset_count), .reset_gap(reset_gap),
        .sync_error(sync_error), .sync_error_count(sync_error_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          smp, hdr, gap, serr, lk;
        logic [15:0] io, qo, ec;
        logic [31:0] rc;
    } ev_t;

    ev_t sb[$];
    int  n_chk = 0;
    int  n_pass = 0;

    // Reference model: a word either extends a marker run (once something
    // has been seen to act as header) or ends it; the run length decides.
    bit          m_have_cand, m_lk, m_have_hdr;
    int          m_run, m_ec;
    logic [31:0] m_cand, m_rc;
    logic [15:0] m_io, m_qo;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    task automatic model_reset();
        m_have_cand = 0; m_lk = 0; m_have_hdr = 0;
        m_run = 0; m_ec = 0; m_cand = 0; m_rc = 0; m_io = 0; m_qo = 0;
    endtask

    task automatic model_word(input logic [15:0] wi, input logic [15:0] wq);
        ev_t e;
        e = '{default: '0};
        if (wi == MW && wq == MW) begin
            if (m_have_cand) begin
                m_run = (m_run >= 255) ? 255 : m_run + 1;
                m_lk  = 0;
            end
        end else begin
            if (m_run == MC) begin
                e.hdr = 1;
                e.gap = m_have_hdr && (m_cand != 0) && (m_cand != m_rc + 1);
                m_rc = m_cand; m_have_hdr = 1; m_lk = 1; e.smp = 1;
            end else if (m_run > 0) begin
                e.serr = 1;
                if (m_ec < 65535) m_ec++;
            end else if (m_lk) begin
                e.smp = 1;
            end
            if (e.smp) begin m_io = wi; m_qo = wq; end
            m_cand = {wq, wi}; m_have_cand = 1; m_run = 0;
        end
        e.lk = m_lk; e.io = m_io; e.qo = m_qo; e.rc = m_rc; e.ec = 16'(m_ec);
        if (e.smp || e.hdr || e.gap || e.serr) sb.push_back(e);
    endtask

    // Called with time just past a rising edge.
    task automatic send(input logic [15:0] wi, input logic [15:0] wq, input int gap);
        strobe_in = 1'b1; i_in = wi; q_in = wq;
        model_word(wi, wq);
        @(posedge clock); #1;
        strobe_in = 1'b0;
        chk("locked", {31'd0, locked}, {31'd0, m_lk});
        repeat (gap) begin @(posedge clock); #1; end
    endtask

    task automatic send_frame(input logic [31:0] hdr, input int nmk, input int gap);
        send(hdr[15:0], hdr[31:16], gap);
        repeat (nmk) send(MW, MW, gap);
    endtask

    task automatic send_data(input int n, input int gap);
        logic [15:0] a, b;
        for (int k = 0; k < n; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (a == MW && b == MW) b = 16'h1234;
            send(a, b, gap);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_smp"},  {31'd0, sample_strobe}, 32'd0);
        chk({tag, "_hdr"},  {31'd0, header_strobe}, 32'd0);
        chk({tag, "_gap"},  {31'd0, reset_gap}, 32'd0);
        chk({tag, "_serr"}, {31'd0, sync_error}, 32'd0);
        chk({tag, "_lock"}, {31'd0, locked}, 32'd0);
        chk({tag, "_io"},   {16'd0, i_out}, 32'd0);
        chk({tag, "_qo"},   {16'd0, q_out}, 32'd0);
        chk({tag, "_rc"},   reset_count, 32'd0);
        chk({tag, "_ec"},   {16'd0, sync_error_count}, 32'd0);
    endtask

    // Monitor: pops one expected event per emitted pulse.
    ev_t mon_e;
    always @(negedge clock) begin
        if (reset === 1'b1 &&
            (sample_strobe || header_strobe || reset_gap || sync_error)) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pulse: smp=%0b hdr=%0b gap=%0b serr=%0b expected none",
                         sample_strobe, header_strobe, reset_gap, sync_error);
            end else begin
                mon_e = sb.pop_front();
                chk("ev_smp",  {31'd0, sample_strobe}, {31'd0, mon_e.smp});
                chk("ev_hdr",  {31'd0, header_strobe}, {31'd0, mon_e.hdr});
                chk("ev_gap",  {31'd0, reset_gap}, {31'd0, mon_e.gap});
                chk("ev_serr", {31'd0, sync_error}, {31'd0, mon_e.serr});
                chk("ev_lock", {31'd0, locked}, {31'd0, mon_e.lk});
                chk("ev_rc",   reset_count, mon_e.rc);
                chk("ev_ec",   {16'd0, sync_error_count}, {16'd0, mon_e.ec});
                if (mon_e.smp) begin
                    chk("ev_io", {16'd0, i_out}, {16'd0, mon_e.io});
                    chk("ev_qo", {16'd0, q_out}, {16'd0, mon_e.qo});
                end
            end
        end
    end

    initial begin
        reset = 1'b0; strobe_in = 1'b0; i_in = '0; q_in = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clock); #1;

        // First frame, header 5, data at 17-cycle spacing.
        send_frame(32'h0000_0005, MC, 0);
        send_data(10, 16);
        chk("rc_first", reset_count, 32'd5);
        chk("ec_first", {16'd0, sync_error_count}, 32'd0);

        // Header 7 after 5 raises reset_gap; header 0 then suppresses it.
        send_frame(32'h0000_0007, MC, 1);
        send_data(4, 2);
        chk("rc_seven", reset_count, 32'd7);
        send_frame(32'h0000_0000, MC, 0);
        send_data(3, 0);
        chk("rc_zero", reset_count, 32'd0);

        // Short marker run: sync error, no samples, then a good frame locks.
        send_frame(32'h0000_0001, MC - 1, 0);
        send_data(5, 1);
        chk("ec_short", {16'd0, sync_error_count}, 32'd1);
        send_frame(32'h0000_0002, MC, 0);
        send_data(4, 0);
        chk("lock_after_short", {31'd0, locked}, 32'd1);

        // Single marker inside a locked stream.
        send(MW, MW, 0);
        send_data(6, 1);
        chk("lock_single_mk", {31'd0, locked}, 32'd0);
        send_frame(32'h0000_0003, MC, 0);
        send_data(3, 0);
        chk("relock", {31'd0, locked}, 32'd1);

        // Back-to-back random frames.
        for (int f = 0; f < 3; f++) begin
            send_frame($urandom, MC, 0);
            send_data(8 + $urandom_range(0, 8), 0);
        end
        chk("rc_b2b", reset_count, m_rc);

        // Async reset in the middle of a marker run.
        send_frame(32'h0000_00AA, 100, 0);
        reset = 1'b0;
        #2;
        model_reset();
        check_all_zero("midreset");
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        send_frame(32'h0000_0010, MC, $urandom_range(0, 2));
        send_data(5, $urandom_range(0, 3));
        chk("rc_after_reset", reset_count, 32'h10);
        chk("lock_after_reset", {31'd0, locked}, 32'd1);

        repeat (5) @(posedge clock);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
